// File: rtl/fetch_bpu_pkg.sv
// fetch_bpu_pkg: types and constants shared by the fetch stage and its BTB.
//   fetch_state_t : fetch sequencer states
//   btb_entry_t   : one BTB entry (valid, tag, target, 2-bit bimodal counter)
//   WEAKLY_NT / WEAKLY_T : counter values used at reset and on allocation
//   cnt_update()  : saturating bimodal counter step
// Tag and target fields are sized for the widest supported address
// (MAX_ADDR_W); narrower configurations zero-extend into them.
package fetch_bpu_pkg;

    localparam int MAX_ADDR_W = 32;

    localparam logic [1:0] WEAKLY_NT = 2'b01;
    localparam logic [1:0] WEAKLY_T  = 2'b10;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] tag;
        logic [MAX_ADDR_W-1:0] target;
        logic [1:0]            cnt;
    } btb_entry_t;

    // Saturating counter: moves toward 3 on taken, toward 0 on not-taken.
    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] result;
        result = cnt;
        if (taken && cnt != 2'b11) begin
            result = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            result = cnt - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped branch target buffer with 2-bit bimodal counters.
//   clk, rst          : clock, asynchronous active-high reset
//   lookup_addr       : address being fetched
//   lookup_taken      : entry hits and its counter predicts taken
//   lookup_next       : predicted next PC (stored target, or addr+4)
//   upd_valid/pc/taken/target : resolved-branch training port
// Lookups are combinational on the current array contents, so a lookup in
// the same cycle as an update to the same index sees the old entry.
module bpu_btb
    import fetch_bpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_taken,
    output logic [ADDR_W-1:0] lookup_next,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    btb_entry_t entries [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_entry;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    btb_entry_t       up_entry;
    logic             up_hit;

    // Byte-offset bits are always zero for word-aligned PCs.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{lookup_addr[1:0], upd_pc[1:0]};

    assign lk_idx   = lookup_addr[IDX_W+1:2];
    assign lk_tag   = lookup_addr[ADDR_W-1:IDX_W+2];
    assign lk_entry = entries[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == MAX_ADDR_W'(lk_tag));

    assign lookup_taken = lk_hit && lk_entry.cnt[1];
    assign lookup_next  = lookup_taken ? lk_entry.target[ADDR_W-1:0]
                                       : lookup_addr + ADDR_W'(4);

    assign up_idx   = upd_pc[IDX_W+1:2];
    assign up_tag   = upd_pc[ADDR_W-1:IDX_W+2];
    assign up_entry = entries[up_idx];
    assign up_hit   = up_entry.valid && (up_entry.tag == MAX_ADDR_W'(up_tag));

    // NOTE: the entry array is built from flops rather than a RAM macro because
    // every valid bit and counter must clear on reset; a RAM cannot do that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAKLY_NT};
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                entries[up_idx].cnt <= cnt_update(up_entry.cnt, upd_taken);
                if (upd_taken) begin
                    entries[up_idx].target <= MAX_ADDR_W'(upd_target);
                end
            end else if (upd_taken) begin
                // Miss on a taken branch: claim the slot, evicting any alias.
                entries[up_idx] <= '{valid:  1'b1,
                                     tag:    MAX_ADDR_W'(up_tag),
                                     target: MAX_ADDR_W'(upd_target),
                                     cnt:    WEAKLY_T};
            end
        end
    end

endmodule

// File: rtl/fetch_bpu.sv
// fetch_bpu: single-issue fetch stage with BTB prediction.
//   CLK, RST            : clock, asynchronous active-high reset
//   imem_req/addr       : held fetch request to instruction memory
//   imem_ready/rdata    : memory response, completes the request
//   out_valid/ready     : valid/ready handshake to decode
//   out_instr/pc        : fetched instruction and its PC
//   out_pred_taken/target : BTB prediction made for out_pc
//   ex_update_*         : resolved-branch training for the BTB
//   ex_mispredict, ex_redirect_pc : flush and restart fetch
// 'pc' is the architectural next-fetch PC; 'req_addr' is what is on the bus.
// They differ only in DROP, where a request issued before a redirect must
// finish at its original address before the redirect PC can go out.
module fetch_bpu
    import fetch_bpu_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               out_pred_taken,
    output logic [ADDR_W-1:0]  out_pred_target,
    input  logic               ex_update_valid,
    input  logic [ADDR_W-1:0]  ex_update_pc,
    input  logic               ex_update_taken,
    input  logic [ADDR_W-1:0]  ex_update_target,
    input  logic               ex_mispredict,
    input  logic [ADDR_W-1:0]  ex_redirect_pc
);

    fetch_state_t       state, state_d;
    logic [ADDR_W-1:0]  pc, pc_d;
    logic [ADDR_W-1:0]  req_addr, req_addr_d;
    logic               valid_d;
    logic [INSTR_W-1:0] instr_d;
    logic [ADDR_W-1:0]  opc_d;
    logic               ptaken_d;
    logic [ADDR_W-1:0]  ptarget_d;

    logic               pred_taken;
    logic [ADDR_W-1:0]  pred_next;

    bpu_btb #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (CLK),
        .rst          (RST),
        .lookup_addr  (req_addr),
        .lookup_taken (pred_taken),
        .lookup_next  (pred_next),
        .upd_valid    (ex_update_valid),
        .upd_pc       (ex_update_pc),
        .upd_taken    (ex_update_taken),
        .upd_target   (ex_update_target)
    );

    // Gated by RST so no request is visible while reset is held.
    assign imem_req  = !RST && (state != HOLD);
    assign imem_addr = req_addr;

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        req_addr_d = req_addr;
        valid_d    = out_valid;
        instr_d    = out_instr;
        opc_d      = out_pc;
        ptaken_d   = out_pred_taken;
        ptarget_d  = out_pred_target;

        unique case (state)
            FETCH: begin
                if (ex_mispredict) begin
                    pc_d    = ex_redirect_pc;
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        req_addr_d = ex_redirect_pc;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ready) begin
                    instr_d    = imem_rdata;
                    opc_d      = req_addr;
                    ptaken_d   = pred_taken;
                    ptarget_d  = pred_next;
                    valid_d    = 1'b1;
                    pc_d       = pred_next;
                    req_addr_d = pred_next;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (ex_mispredict) begin
                    pc_d       = ex_redirect_pc;
                    req_addr_d = ex_redirect_pc;
                    valid_d    = 1'b0;
                    state_d    = FETCH;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (ex_mispredict) begin
                    pc_d    = ex_redirect_pc;
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        req_addr_d = ex_redirect_pc;
                        state_d    = FETCH;
                    end
                end else if (imem_ready) begin
                    req_addr_d = pc;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            req_addr        <= RESET_PC;
            out_valid       <= 1'b0;
            out_instr       <= '0;
            out_pc          <= '0;
            out_pred_taken  <= 1'b0;
            out_pred_target <= '0;
        end else begin
            state           <= state_d;
            pc              <= pc_d;
            req_addr        <= req_addr_d;
            out_valid       <= valid_d;
            out_instr       <= instr_d;
            out_pc          <= opc_d;
            out_pred_taken  <= ptaken_d;
            out_pred_target <= ptarget_d;
        end
    end

endmodule

// File: tb/tb_fetch_bpu.sv
// tb_fetch_bpu: directed self-checking bench for fetch_bpu (default parameters).
// Memory responds with 0xA000_0000 | address when auto_mem is set, otherwise
// the bench drives ready/data by hand. Outputs are sampled 1 ns after the
// rising edge; inputs are changed at the same point.
module tb_fetch_bpu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;
    logic        ex_update_valid;
    logic [31:0] ex_update_pc;
    logic        ex_update_taken;
    logic [31:0] ex_update_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;

    logic        auto_mem;
    logic        man_ready;
    logic [31:0] man_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    always_comb begin
        imem_ready = auto_mem ? imem_req : man_ready;
        imem_rdata = auto_mem ? (32'hA000_0000 | imem_addr) : man_rdata;
    end

    fetch_bpu dut (
        .CLK              (CLK),
        .RST              (RST),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .out_pred_taken   (out_pred_taken),
        .out_pred_target  (out_pred_target),
        .ex_update_valid  (ex_update_valid),
        .ex_update_pc     (ex_update_pc),
        .ex_update_taken  (ex_update_taken),
        .ex_update_target (ex_update_target),
        .ex_mispredict    (ex_mispredict),
        .ex_redirect_pc   (ex_redirect_pc)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST              = 1'b1;
        out_ready        = 1'b0;
        ex_update_valid  = 1'b0;
        ex_update_pc     = '0;
        ex_update_taken  = 1'b0;
        ex_update_target = '0;
        ex_mispredict    = 1'b0;
        ex_redirect_pc   = '0;
        auto_mem         = 1'b0;
        man_ready        = 1'b0;
        man_rdata        = '0;

        // Reset held for two cycles.
        step();
        check("rst_req_c1", imem_req, 1'b0);
        check("rst_valid_c1", out_valid, 1'b0);
        step();
        check("rst_req_c2", imem_req, 1'b0);
        check("rst_valid_c2", out_valid, 1'b0);
        check("rst_addr", imem_addr, 32'h0);

        RST       = 1'b0;
        out_ready = 1'b1;
        auto_mem  = 1'b1;
        #1;
        check("boot_req", imem_req, 1'b1);
        check("boot_addr", imem_addr, 32'h0);

        // Sequential fetch, zero-wait memory: one instruction every 2 cycles.
        step();
        check("seq0_valid", out_valid, 1'b1);
        check("seq0_pc", out_pc, 32'h0);
        check("seq0_instr", out_instr, 32'hA000_0000);
        check("seq0_ptaken", out_pred_taken, 1'b0);
        check("seq0_ptarget", out_pred_target, 32'h4);
        check("seq0_req", imem_req, 1'b0);
        step();
        check("seq_gap_valid", out_valid, 1'b0);
        check("seq_gap_addr", imem_addr, 32'h4);
        step();
        check("seq1_pc", out_pc, 32'h4);
        step();
        step();
        check("seq2_pc", out_pc, 32'h8);
        check("seq2_ptarget", out_pred_target, 32'hC);

        // Backpressure for 5 cycles while training pc=0x10 taken -> 0x40 twice.
        out_ready        = 1'b0;
        ex_update_valid  = 1'b1;
        ex_update_pc     = 32'h10;
        ex_update_taken  = 1'b1;
        ex_update_target = 32'h40;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) ex_update_valid = 1'b0;
            check("hold_valid", out_valid, 1'b1);
            check("hold_pc", out_pc, 32'h8);
            check("hold_instr", out_instr, 32'hA000_0008);
            check("hold_req", imem_req, 1'b0);
        end

        // Mispredict during the hold.
        ex_mispredict  = 1'b1;
        ex_redirect_pc = 32'h10;
        step();
        ex_mispredict = 1'b0;
        out_ready     = 1'b1;
        check("hold_flush_valid", out_valid, 1'b0);
        check("hold_flush_req", imem_req, 1'b1);
        check("hold_flush_addr", imem_addr, 32'h10);
        step();
        check("train_t_valid", out_valid, 1'b1);
        check("train_t_pc", out_pc, 32'h10);
        check("train_t_ptaken", out_pred_taken, 1'b1);
        check("train_t_ptarget", out_pred_target, 32'h40);
        step();
        check("train_t_nextaddr", imem_addr, 32'h40);
        check("train_t_nextreq", imem_req, 1'b1);

        // Two not-taken updates for 0x10 (counter 3 -> 1).
        ex_update_valid = 1'b1;
        ex_update_taken = 1'b0;
        step();
        check("fetch40_pc", out_pc, 32'h40);
        check("fetch40_ptarget", out_pred_target, 32'h44);
        step();
        ex_update_valid = 1'b0;
        // FETCH with memory ready in the same cycle as a mispredict.
        ex_mispredict  = 1'b1;
        ex_redirect_pc = 32'h10;
        step();
        ex_mispredict = 1'b0;
        check("fetch_flush_valid", out_valid, 1'b0);
        check("fetch_flush_addr", imem_addr, 32'h10);
        step();
        check("train_nt_pc", out_pc, 32'h10);
        check("train_nt_instr", out_instr, 32'hA000_0010);
        check("train_nt_ptaken", out_pred_taken, 1'b0);
        check("train_nt_ptarget", out_pred_target, 32'h14);
        step();
        check("wait_req_addr", imem_addr, 32'h14);

        // Three-cycle memory wait with a redirect to 0x100 on wait cycle 1.
        auto_mem       = 1'b0;
        man_ready      = 1'b0;
        ex_mispredict  = 1'b1;
        ex_redirect_pc = 32'h100;
        step();
        ex_mispredict = 1'b0;
        check("drop_addr_w1", imem_addr, 32'h14);
        check("drop_req_w1", imem_req, 1'b1);
        check("drop_valid_w1", out_valid, 1'b0);
        step();
        check("drop_addr_w2", imem_addr, 32'h14);
        man_ready = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        step();
        man_ready = 1'b0;
        check("drop_discard_valid", out_valid, 1'b0);
        check("drop_restart_addr", imem_addr, 32'h100);
        check("drop_restart_req", imem_req, 1'b1);
        auto_mem = 1'b1;
        step();
        check("redir_pc", out_pc, 32'h100);
        check("redir_instr", out_instr, 32'hA000_0100);
        check("redir_ptarget", out_pred_target, 32'h104);

        // Alias 0x50 (same index as 0x10): 4 taken then 1 not-taken update.
        out_ready        = 1'b0;
        ex_update_valid  = 1'b1;
        ex_update_pc     = 32'h50;
        ex_update_taken  = 1'b1;
        ex_update_target = 32'h80;
        step();
        step();
        step();
        step();
        ex_update_taken = 1'b0;
        step();
        ex_update_valid = 1'b0;
        check("alias_hold_pc", out_pc, 32'h100);
        ex_mispredict  = 1'b1;
        ex_redirect_pc = 32'h50;
        step();
        ex_mispredict = 1'b0;
        out_ready     = 1'b1;
        check("alias_flush_valid", out_valid, 1'b0);
        check("alias_flush_addr", imem_addr, 32'h50);
        step();
        check("sat_pc", out_pc, 32'h50);
        check("sat_ptaken", out_pred_taken, 1'b1);
        check("sat_ptarget", out_pred_target, 32'h80);
        ex_mispredict  = 1'b1;
        ex_redirect_pc = 32'h10;
        step();
        ex_mispredict = 1'b0;
        check("evict_flush_addr", imem_addr, 32'h10);
        check("evict_flush_valid", out_valid, 1'b0);
        step();
        check("evict_pc", out_pc, 32'h10);
        check("evict_ptaken", out_pred_taken, 1'b0);
        check("evict_ptarget", out_pred_target, 32'h14);

        // Reset asserted mid-operation takes effect immediately.
        RST = 1'b1;
        #1;
        check("midrst_req", imem_req, 1'b0);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_pc", out_pc, 32'h0);
        step();
        RST = 1'b0;
        #1;
        check("midrst_boot_req", imem_req, 1'b1);
        check("midrst_boot_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
